fp_convert_pipe: RTL and testbench

//  Pipelined, parametrised linear-to-floating-point converter. Converts a two's-complement sample
//  D into sign S, exponent E and significand F, with value = F * 2^E.

---
 rtl/fp_conv_pkg.sv | 18 +
 rtl/fp_lead_extract.sv | 39 +++
 rtl/fp_convert_pipe.sv | 131 +++++++++++++
 tb/tb_fp_convert_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared default widths, limits and helpers for fp_convert_pipe
package fp_conv_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int EXP_W_DEF = 3;
  localparam int SIG_W_DEF = 4;

  localparam int E_MAX = (1 << EXP_W_DEF) - 1;
  localparam logic [SIG_W_DEF-1:0] SAT_F = {SIG_W_DEF{1'b1}};

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fp_lead_extract.sv
// rtl/fp_lead_extract.sv - leading-one detect, significand extraction and round bit
// Purely combinational; sits between the S1 and S2 registers of fp_convert_pipe.
module fp_lead_extract
  import fp_conv_pkg::*;
#(
  parameter int MAG_W = IN_W_DEF - 1,
  parameter int EXP_W = EXP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic [MAG_W-1:0] mag,
  output logic [EXP_W-1:0] e_raw,
  output logic [SIG_W-1:0] f_raw,
  output logic             round_bit
);

  localparam int PW = clog2(MAG_W);

  logic [PW-1:0] p;
  logic [PW-1:0] sh;

  always_comb begin
    p = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) p = PW'(i);
    end
    sh = p - PW'(SIG_W - 1);
    if (p < PW'(SIG_W)) begin
      e_raw     = '0;
      f_raw     = mag[SIG_W-1:0];
      round_bit = 1'b0;
    end else begin
      // sh >= 1 here, so the first dropped bit sits just below the window
      e_raw     = EXP_W'(sh);
      f_raw     = SIG_W'(mag >> sh);
      round_bit = mag[sh - PW'(1)];
    end
  end

endmodule

// File: rtl/fp_convert_pipe.sv
// rtl/fp_convert_pipe.sv - 3-stage linear-to-floating-point converter with valid/ready stream
// Optional FP_CONVERT_STATUS_EN adds out_sat and the saturating sat_cnt counter.
module fp_convert_pipe
  import fp_conv_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [SIG_W-1:0] out_f
`ifdef FP_CONVERT_STATUS_EN
  ,
  output logic             out_sat,
  output logic [7:0]       sat_cnt
`endif
);

  localparam int MAG_W = IN_W - 1;
  localparam logic [EXP_W-1:0] E_MAX_L = '1;

  logic             advance;
  logic             neg_max1_d;
  logic [MAG_W-1:0] mag1_d;
  logic             v1_q, s1_q, neg_max1_q;
  logic [MAG_W-1:0] mag1_q;

  logic [EXP_W-1:0] e_raw;
  logic [SIG_W-1:0] f_raw;
  logic             round_bit;
  logic             v2_q, s2_q, neg_max2_q, r2_q;
  logic [EXP_W-1:0] e2_q;
  logic [SIG_W-1:0] f2_q;

  logic [SIG_W:0]   f_sum;
  logic [SIG_W-1:0] f_rnd, f3_d;
  logic [EXP_W:0]   e_rnd;
  logic [EXP_W-1:0] e3_d;
  logic             sat3_d;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  // The most-negative input has no positive twin; clamp it and force saturation later
  assign neg_max1_d = (in_d == {1'b1, {MAG_W{1'b0}}});
  assign mag1_d     = neg_max1_d ? {MAG_W{1'b1}}
                    : (in_d[IN_W-1] ? MAG_W'(-in_d) : in_d[MAG_W-1:0]);

  fp_lead_extract #(
    .MAG_W(MAG_W),
    .EXP_W(EXP_W),
    .SIG_W(SIG_W)
  ) u_lead_extract (
    .mag      (mag1_q),
    .e_raw    (e_raw),
    .f_raw    (f_raw),
    .round_bit(round_bit)
  );

  always_comb begin
    f_sum = {1'b0, f2_q} + {{SIG_W{1'b0}}, r2_q};
    f_rnd = f_sum[SIG_W-1:0];
    e_rnd = {1'b0, e2_q};
    if (f_sum[SIG_W]) begin
      f_rnd = {1'b1, {(SIG_W-1){1'b0}}};
      e_rnd = {1'b0, e2_q} + (EXP_W+1)'(1);
    end
    sat3_d = neg_max2_q || (e_rnd > {1'b0, E_MAX_L});
    e3_d   = sat3_d ? E_MAX_L : e_rnd[EXP_W-1:0];
    f3_d   = sat3_d ? {SIG_W{1'b1}} : f_rnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      s1_q       <= 1'b0;
      neg_max1_q <= 1'b0;
      mag1_q     <= '0;
      v2_q       <= 1'b0;
      s2_q       <= 1'b0;
      neg_max2_q <= 1'b0;
      r2_q       <= 1'b0;
      e2_q       <= '0;
      f2_q       <= '0;
      out_valid  <= 1'b0;
      out_s      <= 1'b0;
      out_e      <= '0;
      out_f      <= '0;
`ifdef FP_CONVERT_STATUS_EN
      out_sat    <= 1'b0;
`endif
    end else if (advance) begin
      v1_q       <= in_valid;
      s1_q       <= in_d[IN_W-1];
      neg_max1_q <= neg_max1_d;
      mag1_q     <= mag1_d;
      v2_q       <= v1_q;
      s2_q       <= s1_q;
      neg_max2_q <= neg_max1_q;
      r2_q       <= round_bit;
      e2_q       <= e_raw;
      f2_q       <= f_raw;
      out_valid  <= v2_q;
      out_s      <= s2_q;
      out_e      <= e3_d;
      out_f      <= f3_d;
`ifdef FP_CONVERT_STATUS_EN
      out_sat    <= sat3_d;
`endif
    end
  end

`ifdef FP_CONVERT_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= 8'd0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != 8'hFF)) begin
      sat_cnt <= sat_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_convert_pipe.sv
// tb/tb_fp_convert_pipe.sv - randomized and directed self-checking bench for fp_convert_pipe
module tb_fp_convert_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_d;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
`ifdef FP_CONVERT_STATUS_EN
  logic        out_sat;
  logic [7:0]  sat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [8:0] exp_q[$];

  fp_convert_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_e    (out_e),
    .out_f    (out_f)
`ifdef FP_CONVERT_STATUS_EN
    ,
    .out_sat  (out_sat),
    .sat_cnt  (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {sat, S, E, F}, value = F * 2^E, found by shrinking |D| until it fits SIG_W bits
  function automatic logic [8:0] ref_conv(input logic [11:0] d);
    int v, mag, e, f, r;
    logic s, sat;
    v   = int'($signed(d));
    s   = (v < 0);
    mag = s ? -v : v;
    e   = 0;
    while ((mag >> e) >= 16) e++;
    f = mag >> e;
    r = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
    f = f + r;
    if (f == 16) begin
      f = 8;
      e = e + 1;
    end
    sat = (e > 7) || (v == -2048);
    if (sat) begin
      e = 7;
      f = 15;
    end
    return {sat, s, e[2:0], f[3:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [8:0] exp;
        n_out++;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check_eq("sb_s", 32'(out_s), 32'(exp[7]));
          check_eq("sb_e", 32'(out_e), 32'(exp[6:4]));
          check_eq("sb_f", 32'(out_f), 32'(exp[3:0]));
`ifdef FP_CONVERT_STATUS_EN
          check_eq("sb_sat", 32'(out_sat), 32'(exp[8]));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_conv(in_d));
        n_acc++;
      end
    end
  end

  task automatic send_one(input string tag, input logic [11:0] d, input logic es,
                          input logic [2:0] ee, input logic [3:0] ef);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_d      = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 10);
    check_eq({tag, "_lat"}, 32'(n), 32'd3);
    check_eq({tag, "_s"}, 32'(out_s), 32'(es));
    check_eq({tag, "_e"}, 32'(out_e), 32'(ee));
    check_eq({tag, "_f"}, 32'(out_f), 32'(ef));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bp_samp[5];
    logic [10:0] snap;
    int acc0, out0, vcnt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_d      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sef", {21'd0, out_s, out_e, out_f}, 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FP_CONVERT_STATUS_EN
    check_eq("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    send_one("zero",   12'd0,    1'b0, 3'd0, 4'd0);
    send_one("p422",   12'd422,  1'b0, 3'd5, 4'd13);
    send_one("n422",   12'hE5A,  1'b1, 3'd5, 4'd13);
    send_one("rnd46",  12'd46,   1'b0, 3'd2, 4'd12);
    send_one("rnd31",  12'd31,   1'b0, 3'd2, 4'd8);
    send_one("nornd9", 12'd9,    1'b0, 3'd0, 4'd9);
    send_one("satpos", 12'h7FF,  1'b0, 3'd7, 4'd15);
    send_one("satneg", 12'h800,  1'b1, 3'd7, 4'd15);
    @(posedge clk); #1;
`ifdef FP_CONVERT_STATUS_EN
    check_eq("sat_cnt2", 32'(sat_cnt), 32'd2);
`endif

    // Backpressure: 5 samples offered while the sink stalls for 6 cycles
    for (int i = 0; i < 5; i++) bp_samp[i] = 12'($urandom);
    out0 = n_out;
    snap = '0;
    fork
      begin
        int idx;
        logic acc;
        idx = 0;
        while (idx < 5) begin
          in_valid = 1'b1;
          in_d     = bp_samp[idx];
          @(negedge clk);
          acc = in_ready;
          @(posedge clk); #1;
          if (acc) idx++;
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check_eq("bp_in_ready", 32'(in_ready), 32'(k < 3));
          check_eq("bp_out_valid", 32'(out_valid), 32'(k >= 3));
          if (k == 3) snap = {out_s, out_e, out_f, 3'b000};
          if (k > 3) check_eq("bp_stable", 32'({out_s, out_e, out_f, 3'b000}), 32'(snap));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check_eq("bp_count", 32'(n_out - out0), 32'd5);
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

    // Throughput: continuous stream of random samples
    acc0 = n_acc;
    out0 = n_out;
    vcnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_d     = (i % 17 == 5) ? 12'h800 : 12'($urandom);
      if (out_valid) vcnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("tp_accepted", 32'(n_acc - acc0), 32'd100);
    check_eq("tp_results", 32'(n_out - out0), 32'd100);
    check_eq("tp_valid_cycles", 32'(vcnt), 32'd97);

    // Reset with three samples in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_d     = 12'd100 + 12'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("mr_async_valid", 32'(out_valid), 32'd0);
    check_eq("mr_async_sef", {21'd0, out_s, out_e, out_f}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef FP_CONVERT_STATUS_EN
    check_eq("mr_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    vcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    check_eq("mr_no_stale", 32'(vcnt), 32'd0);
    send_one("mr_first", 12'd422, 1'b0, 3'd5, 4'd13);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mr_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
